// File: rtl/axil_init.sv
// AXI4-Lite single-transaction command master: one outstanding read or write.
// Optional handshake timeout is built when AXIL_INIT_TIMEOUT_EN is defined.
module axil_init #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_resp,
    output logic        awvalid,
    output logic [15:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [15:0] wdata,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        arvalid,
    output logic [15:0] araddr,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [15:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t      state, state_n;
    logic        cmd_ready_n, rsp_valid_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [15:0] rsp_data_n, awaddr_n, wdata_n, araddr_n;
    logic [1:0]  rsp_resp_n;

`ifdef AXIL_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          waiting;
    assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_n     = state;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_resp_n  = rsp_resp;
        awvalid_n   = awvalid;
        awaddr_n    = awaddr;
        wvalid_n    = wvalid;
        wdata_n     = wdata;
        bready_n    = bready;
        arvalid_n   = arvalid;
        araddr_n    = araddr;
        rready_n    = rready;
        case (state)
            IDLE: if (cmd_valid) begin
                if (cmd_write) begin
                    state_n   = WR_REQ;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    awaddr_n  = cmd_addr;
                    wdata_n   = cmd_data;
                end else begin
                    state_n   = RD_REQ;
                    arvalid_n = 1'b1;
                    araddr_n  = cmd_addr;
                end
            end
            WR_REQ: begin
                // A dropped valid means that channel already handshook.
                if (awvalid && awready) awvalid_n = 1'b0;
                if (wvalid && wready)   wvalid_n  = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: if (bvalid) begin
                state_n     = DONE;
                bready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_data_n  = '0;
                rsp_resp_n  = bresp;
            end
            RD_REQ: if (arready) begin
                state_n   = RD_RESP;
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
            end
            RD_RESP: if (rvalid) begin
                state_n     = DONE;
                rready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_data_n  = rdata;
                rsp_resp_n  = rresp;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef AXIL_INIT_TIMEOUT_EN
        // A completing handshake takes priority over an expiring counter.
        if (waiting && state_n == state && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_n     = DONE;
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_data_n  = '0;
            rsp_resp_n  = 2'b10;
        end
        cnt_n = (waiting && state_n == state) ? cnt + 1'b1 : '0;
`endif
        cmd_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
`ifdef AXIL_INIT_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_resp  <= rsp_resp_n;
            awvalid   <= awvalid_n;
            awaddr    <= awaddr_n;
            wvalid    <= wvalid_n;
            wdata     <= wdata_n;
            bready    <= bready_n;
            arvalid   <= arvalid_n;
            araddr    <= araddr_n;
            rready    <= rready_n;
`ifdef AXIL_INIT_TIMEOUT_EN
            cnt       <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_axil_init.sv
// Self-checking bench for axil_init: directed vector table, randomized
// transactions against a protocol-level slave/latency model, reset and timeout cases.
module tb_axil_init;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr, cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [15:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_init #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
    );

    // d1: aw (or ar) accept delay, d2: w accept delay (writes), d3: b (or r) delay
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          d1, d2, d3;
        logic [1:0]  resp;
        logic [15:0] rd;
        bit          noise;
        logic [15:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    // Latency counted from the accept cycle (cycle 1) to the rsp_valid cycle inclusive.
    function automatic int model_lat(input vec_t v);
        int req;
        req = v.wr ? ((v.d1 > v.d2) ? v.d1 : v.d2) : v.d1;
        return req + v.d3 + 4;
    endfunction

    task automatic run_txn(input vec_t v);
        int cyc = 0, pulses = 0, done_cyc = 0;
        int h1 = 0, h2 = 0, c1 = 0, c2 = 0, c3 = 0;
        int bad_stable = 0, bad_drop = 0, ready_bad = 0;
        bit hs1 = 0, hs2 = 0, hs3 = 0, first_ok = 0, fin = 0, after_ready = 0;
        logic [15:0] got_data = 'x;
        logic [1:0]  got_resp = 'x;
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_data = v.data;
        @(posedge clk); #1;
        cmd_valid = 0;
        while (!fin) begin
            cyc++;
            if (done_cyc != 0) begin
                after_ready = cmd_ready;
                fin = 1;
            end else if (cyc > 60) begin
                fin = 1;
            end else begin
                if (cmd_ready) ready_bad++;
                if (rsp_valid) begin
                    pulses++; done_cyc = cyc; got_data = rsp_data; got_resp = rsp_resp;
                end
                if (cyc == 1) first_ok = v.wr ? (awvalid && wvalid) : arvalid;
                cmd_valid = (v.noise && done_cyc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_data = 16'($urandom);
                if (v.wr) begin
                    if (hs1 && hs2 && !hs3) begin
                        bvalid = (c3 >= v.d3); bresp = v.resp;
                        if (bvalid && bready) hs3 = 1;
                        c3++;
                    end else bvalid = 0;
                    if (awvalid) begin
                        h1++;
                        if (awaddr !== v.addr) bad_stable++;
                        if (hs1) bad_drop++;
                    end else if (!hs1 && done_cyc == 0) bad_drop++;
                    if (wvalid) begin
                        h2++;
                        if (wdata !== v.data) bad_stable++;
                        if (hs2) bad_drop++;
                    end else if (!hs2 && done_cyc == 0) bad_drop++;
                    if (!hs1 && awvalid) begin
                        awready = (c1 == v.d1); if (awready) hs1 = 1; c1++;
                    end else awready = 0;
                    if (!hs2 && wvalid) begin
                        wready = (c2 == v.d2); if (wready) hs2 = 1; c2++;
                    end else wready = 0;
                end else begin
                    if (hs1 && !hs3) begin
                        rvalid = (c3 >= v.d3); rresp = v.resp;
                        rdata = rvalid ? v.rd : 16'($urandom);
                        if (rvalid && rready) hs3 = 1;
                        c3++;
                    end else rvalid = 0;
                    if (arvalid) begin
                        h1++;
                        if (araddr !== v.addr) bad_stable++;
                        if (hs1) bad_drop++;
                    end else if (!hs1 && done_cyc == 0) bad_drop++;
                    if (!hs1 && arvalid) begin
                        arready = (c1 == v.d1); if (arready) hs1 = 1; c1++;
                    end else arready = 0;
                end
                @(posedge clk); #1;
            end
        end
        idle_slave();
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) pulses++;
            if (!cmd_ready) ready_bad++;
            @(posedge clk); #1;
        end
        check("rsp_pulses", pulses, 1);
        check("rsp_data", got_data, v.exp_data);
        check("rsp_resp", got_resp, v.exp_resp);
        check("latency", done_cyc + 1, v.exp_lat);
        check("first_valid", first_ok, 1);
        check("ch1_valid_cycles", h1, v.d1 + 1);
        if (v.wr) check("w_valid_cycles", h2, v.d2 + 1);
        check("chan_stable", bad_stable, 0);
        check("valid_drop", bad_drop, 0);
        check("cmd_ready_busy", ready_bad, 0);
        check("cmd_ready_after", after_ready, 1);
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        int   arv_hi, pulses;
        logic [1:0]  t_resp;
        logic [15:0] t_data;

        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0;
        idle_slave();
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("reset_data", {awaddr, wdata}, 0);
        check("reset_rsp", {araddr, rsp_data, 14'd0, rsp_resp}, 0);
        rst = 0;

        //         wr addr      data      d1 d2 d3 resp  rd        noise exp_data  exp_resp lat
        tbl[0] = '{1, 16'h0002, 16'h0040, 0, 3, 0, 2'd0, 16'h0000, 0, 16'h0000, 2'd0, 7};
        tbl[1] = '{0, 16'h0004, 16'h0000, 0, 0, 0, 2'd0, 16'h1234, 0, 16'h1234, 2'd0, 4};
        tbl[2] = '{1, 16'h0008, 16'h5A5A, 1, 1, 2, 2'd2, 16'h0000, 1, 16'h0000, 2'd2, 7};
        tbl[3] = '{0, 16'h00F0, 16'h0000, 2, 0, 1, 2'd3, 16'hBEEF, 1, 16'hBEEF, 2'd3, 7};
        tbl[4] = '{1, 16'hFFFE, 16'hFFFF, 0, 0, 0, 2'd3, 16'h0000, 0, 16'h0000, 2'd3, 4};
        tbl[5] = '{0, 16'h0100, 16'h0000, 0, 0, 3, 2'd2, 16'h8001, 0, 16'h8001, 2'd2, 7};
        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        for (int n = 0; n < 40; n++) begin
            v.wr    = 1'($urandom);
            v.addr  = 16'($urandom);
            v.data  = 16'($urandom);
            v.d1    = $urandom_range(0, 3);
            v.d2    = $urandom_range(0, 3);
            v.d3    = $urandom_range(0, 3);
            v.resp  = 2'($urandom);
            v.rd    = 16'($urandom);
            v.noise = 1'($urandom);
            v.exp_data = v.wr ? 16'h0000 : v.rd;
            v.exp_resp = v.resp;
            v.exp_lat  = model_lat(v);
            run_txn(v);
        end

        // Reset while waiting for read data: transaction is dropped silently.
        arready = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk); #1;
        arready = 0;
        check("rd_resp_rready", rready, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("rst_mid_data", {awaddr, wdata, araddr, rsp_data, 14'd0, rsp_resp}, 0);
        rvalid = 1; rdata = 16'hDEAD; rresp = 0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) pulses++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_rsp", pulses, 0);
        idle_slave();

        // Read address never accepted.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0020;
        @(posedge clk); #1;
        cmd_valid = 0;
        arv_hi = 0; pulses = 0; t_resp = 'x; t_data = 'x;
        for (int i = 0; i < 100; i++) begin
            if (arvalid) arv_hi++;
            if (rsp_valid) begin pulses++; t_resp = rsp_resp; t_data = rsp_data; end
            @(posedge clk); #1;
        end
`ifdef AXIL_INIT_TIMEOUT_EN
        check("timeout_arvalid_cycles", arv_hi, 8);
        check("timeout_pulses", pulses, 1);
        check("timeout_resp", t_resp, 2'd2);
        check("timeout_data", t_data, 0);
        check("timeout_cmd_ready", cmd_ready, 1);
`else
        check("no_timeout_arvalid_cycles", arv_hi, 100);
        check("no_timeout_pulses", pulses, 0);
        check("no_timeout_cmd_ready", cmd_ready, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
